playfield_loader: RTL and testbench
===================================

Name: playfield_loader

Overview:
- Writer side of the playfield maze interface. It accepts a byte stream over a valid/ready handshake and assembles 32-bit maze rows.
- Rows are written into a back buffer of a double-buffered row RAM. The buffers swap on the next vsync rising edge after a full 28-row load.
- The front buffer serves the renderer with the standard tile lookup: x = hpos[7:3], y = vpos[7:3] - Y_OFFSET, gfx = row[y][x]. Obstacle layouts can therefore change between frames without tearing.

Parameters:
ROWS, 28, maze rows per frame (max 32)
COLS, 32, bits per row (fixed by a 4-byte row assembly)
Y_OFFSET, 2, tile rows subtracted from vpos[7:3] before lookup

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a new load when idle
in_data  input  8  stream byte; first byte of a row lands in bits 31:24
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts the byte this cycle
vsync  input  1  frame sync, level; the rising edge is the swap point
hpos  input  9  beam horizontal position
vpos  input  9  beam vertical position
busy  output  1  state is LOAD or PEND
swapped  output  1  one-cycle pulse when the buffers swap
have_frame  output  1  at least one complete frame has been swapped in
playfield_gfx  output  1  registered playfield pixel

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE; in_ready, busy, swapped, have_frame, playfield_gfx = 0.
  - front_sel=0; byte_cnt=0; row_cnt=0; vsync_d=0.
  - RAM contents are not reset. Partially loaded data is discarded.
- A byte is accepted on a clk edge where in_valid & in_ready.
- States:
  - IDLE:
    - in_ready=0.
    - start=1 -> LOAD; byte_cnt=0, row_cnt=0.
  - LOAD:
    - in_ready=1.
    - On each accept: shift = {shift[23:0], in_data}; byte_cnt++ (2-bit, wraps).
    - On the accept with byte_cnt==3: write {shift[23:0], in_data} to back[row_cnt] on the same edge; row_cnt++.
    - If row_cnt==ROWS-1 on that write -> PEND.
  - PEND:
    - in_ready=0.
    - On a vsync rising edge (vsync & ~vsync_d, with vsync_d registered every cycle): front_sel toggles, swapped=1 for one cycle, have_frame=1, -> IDLE.
- start is ignored in LOAD and PEND.
- A vsync edge in IDLE or LOAD never swaps.
- If the final byte is accepted on the same edge as a vsync rise, the state enters PEND and waits for the next rise.
- Back buffer = ~front_sel. Writes never target the buffer being read.
- Read path, one-cycle latency:
  - x = hpos[7:3]; y = vpos[7:3] - Y_OFFSET, computed modulo 32 (5-bit wrap).
  - playfield_gfx <= have_frame & (y < ROWS) & front[y][x].
  - Bit x=0 is the row LSB, i.e. the last byte's bit 0.
  - hpos[8] and vpos[8] are ignored.
- A read and a write in the same cycle are independent, since they always address different buffers.
- After have_frame=1 it stays 1 until reset.

Test Plan:
1. Reset:
   - Assert reset_n=0 mid-cycle -> all outputs 0 immediately.
   - Release; sweep hpos/vpos -> playfield_gfx=0 throughout.
2. Full load and swap:
   - start, then 112 bytes: row0 = FF FF FF FF, row1 = 80 00 00 01, remaining rows 00; in_ready=0 after the 112th accept.
   - Pulse vsync -> swapped=1 for exactly one cycle, have_frame=1.
   - (hpos=0, vpos=16) -> gfx=1 one cycle later.
   - (hpos=0, vpos=24) -> gfx=1; (hpos=248, vpos=24) -> gfx=1; (hpos=8, vpos=24) -> gfx=0.
3. Out-of-range rows:
   - vpos=8 (y wraps to 31) -> gfx=0.
   - vpos=240 (y=28) -> gfx=0.
   - vpos=0 -> gfx=0.
4. Backpressure and gaps:
   - Random in_valid gaps during load -> exactly 112 bytes accepted, rows intact.
   - A 113th byte is held, with in_ready=0.
   - start during LOAD has no effect.
5. Double buffering:
   - Begin a second load with all-zero rows; pulse vsync after 60 bytes -> no swap, and (0,16) still reads 1.
   - Complete the load and pulse vsync -> swap; (0,16) reads 0.
   - Final-byte-and-vsync-rise on the same edge -> swap occurs only on the next rise.
6. Reset mid-load:
   - reset_n low after 50 bytes of a first load -> in_ready=0, busy=0, have_frame=0, gfx=0.
   - A new start and full load then behaves as in scenario 2.

Source files
------------

// File: rtl/playfield_loader.sv
// Playfield maze loader: assembles 32-bit rows from a byte stream into a
// double-buffered row RAM and serves tile pixels to the renderer from the front half.
`timescale 1ns/1ps

module playfield_loader #(
  parameter int ROWS     = 28,
  parameter int COLS     = 32,
  parameter int Y_OFFSET = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       vsync,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic       busy,
  output logic       swapped,
  output logic       have_frame,
  output logic       playfield_gfx
);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  // Both buffers share one array; the MSB of the address selects the half.
  logic [COLS-1:0] ram [0:63];

  state_t      state;
  logic        front_sel;
  logic        vsync_d;
  logic [1:0]  byte_cnt;
  logic [4:0]  row_cnt;
  logic [23:0] shift;

  logic            accept;
  logic            wr_en;
  logic            vsync_rise;
  logic [4:0]      tile_x;
  logic [4:0]      tile_y;
  logic            y_ok;
  logic [COLS-1:0] rd_row;
  logic            unused_pos;

  assign accept     = in_valid & in_ready;
  assign wr_en      = accept & (byte_cnt == 2'd3);
  assign vsync_rise = vsync & ~vsync_d;
  assign tile_x     = hpos[7:3];
  assign tile_y     = vpos[7:3] - 5'(Y_OFFSET);
  assign y_ok       = {1'b0, tile_y} < 6'(ROWS);
  assign rd_row     = ram[{front_sel, tile_y}];
  assign unused_pos = ^{hpos[8], hpos[2:0], vpos[8], vpos[2:0]};

  // NOTE: the row RAM has no reset; stale rows are masked by have_frame and
  // every row of the back buffer is rewritten before it can become the front.
  always_ff @(posedge clk) begin
    if (wr_en) ram[{~front_sel, row_cnt}] <= {shift, in_data};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, e.g. vsync_d and the rise detect stay one cycle apart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      swapped       <= 1'b0;
      have_frame    <= 1'b0;
      playfield_gfx <= 1'b0;
      front_sel     <= 1'b0;
      vsync_d       <= 1'b0;
      byte_cnt      <= 2'd0;
      row_cnt       <= 5'd0;
      shift         <= 24'd0;
    end else begin
      vsync_d       <= vsync;
      swapped       <= 1'b0;
      playfield_gfx <= have_frame & y_ok & rd_row[tile_x];

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            byte_cnt <= 2'd0;
            row_cnt  <= 5'd0;
          end
        end
        LOAD: begin
          if (accept) begin
            shift    <= {shift[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              row_cnt <= row_cnt + 5'd1;
              if (row_cnt == LAST_ROW) begin
                state    <= PEND;
                in_ready <= 1'b0;
              end
            end
          end
        end
        PEND: begin
          // The rise that coincides with the final byte was already consumed
          // by vsync_d, so only a later rise can swap.
          if (vsync_rise) begin
            front_sel  <= ~front_sel;
            swapped    <= 1'b1;
            have_frame <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_loader.sv
// Scoreboard bench for playfield_loader: stimulus pushes expectations derived
// from a frame-level model; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_playfield_loader;

  localparam int ROWS     = 28;
  localparam int Y_OFFSET = 2;
  localparam int NBYTES   = ROWS * 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       vsync = 1'b0;
  logic [8:0] hpos = 9'd0;
  logic [8:0] vpos = 9'd0;
  logic       busy;
  logic       swapped;
  logic       have_frame;
  logic       playfield_gfx;

  playfield_loader #(.ROWS(ROWS), .COLS(32), .Y_OFFSET(Y_OFFSET)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .vsync(vsync), .hpos(hpos),
    .vpos(vpos), .busy(busy), .swapped(swapped), .have_frame(have_frame),
    .playfield_gfx(playfield_gfx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t chk_q[$];
  logic gfx_exp_q[$];
  logic swap_exp_q[$];
  logic probe = 1'b0, probe_q = 1'b0;
  logic vs_probe = 1'b0, vs_probe_q = 1'b0;
  logic mon_en = 1'b0;
  int   acc_cnt = 0;

  // Frame-level reference model
  logic [31:0] fr      [ROWS];
  logic [31:0] m_front [ROWS];
  logic [31:0] m_back  [ROWS];
  bit          m_have;
  int          m_count;

  always @(posedge clk) begin
    probe_q    <= probe;
    vs_probe_q <= vs_probe;
    if (reset_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check(c.name, c.act, c.exp);
    end
    if (mon_en) begin
      if (probe_q) begin
        if (gfx_exp_q.size() == 0) check("gfx_q_empty", 32'd1, 32'd0);
        else check("gfx", {31'd0, playfield_gfx}, {31'd0, gfx_exp_q.pop_front()});
      end
      if (vs_probe_q) begin
        if (swap_exp_q.size() == 0) check("swap_q_empty", 32'd1, 32'd0);
        else check("swapped", {31'd0, swapped}, {31'd0, swap_exp_q.pop_front()});
      end else if (swapped !== 1'b0) begin
        check("swapped_stray", {31'd0, swapped}, 32'd0);
      end
    end
  end

  task automatic expect_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  function automatic logic ref_gfx(input int h, input int v);
    int x = (h / 8) % 32;
    int y = ((v / 8) % 32 - Y_OFFSET + 32) % 32;
    if (!m_have || y >= ROWS) return 1'b0;
    return m_front[y][x];
  endfunction

  task automatic model_reset();
    m_have  = 0;
    m_count = 0;
  endtask

  task automatic probe_rd(input int h, input int v);
    @(negedge clk);
    hpos  = 9'(h);
    vpos  = 9'(v);
    probe = 1'b1;
    gfx_exp_q.push_back(ref_gfx(h, v));
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input bit gaps, input bit last_vs);
    for (int i = 0; i < n; i++) begin
      int k = m_count;
      logic [7:0] b = fr[k / 4][31 - 8 * (k % 4) -: 8];
      int t = 0;
      bit ok = 1;
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      if (last_vs && i == n - 1) begin
        vsync    = 1'b1;
        vs_probe = 1'b1;
        swap_exp_q.push_back(1'b0);
      end
      while (in_ready !== 1'b1) begin
        @(negedge clk);
        t++;
        if (t > 50) begin
          expect_now("in_ready_timeout", 32'd0, 32'd1);
          ok = 0;
          break;
        end
      end
      if (!ok) break;
      m_back[k / 4][31 - 8 * (k % 4) -: 8] = b;
      m_count++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    vsync    = 1'b0;
    vs_probe = 1'b0;
  endtask

  task automatic pulse_vsync();
    bit exp = (m_count == NBYTES);
    @(negedge clk);
    vsync    = 1'b1;
    vs_probe = 1'b1;
    swap_exp_q.push_back(exp);
    if (exp) begin
      foreach (m_front[i]) m_front[i] = m_back[i];
      m_have  = 1;
      m_count = 0;
    end
    @(negedge clk);
    vsync    = 1'b0;
    vs_probe = 1'b0;
    @(negedge clk);
    expect_now("have_frame", {31'd0, have_frame}, {31'd0, m_have});
  endtask

  task automatic full_load_check(input bit gaps);
    int base = acc_cnt;
    do_start();
    send_bytes(NBYTES, gaps, 0);
    expect_now("accepted", 32'(acc_cnt - base), 32'(NBYTES));
    expect_now("in_ready_full", {31'd0, in_ready}, 32'd0);
    expect_now("busy_pend", {31'd0, busy}, 32'd1);
  endtask

  task automatic scenario2_frame();
    foreach (fr[i]) fr[i] = 32'd0;
    fr[0] = 32'hFFFF_FFFF;
    fr[1] = 32'h8000_0001;
  endtask

  task automatic scenario2_probes();
    probe_rd(0, 16);
    probe_rd(0, 24);
    probe_rd(248, 24);
    probe_rd(8, 24);
  endtask

  task automatic random_probes(input int n);
    for (int i = 0; i < n; i++)
      probe_rd(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    model_reset();

    // 1. Reset asserted mid-cycle
    #12;
    reset_n = 1'b0;
    #1;
    mon_en = 1'b1;
    expect_now("rst_in_ready", {31'd0, in_ready}, 32'd0);
    expect_now("rst_busy", {31'd0, busy}, 32'd0);
    expect_now("rst_swapped", {31'd0, swapped}, 32'd0);
    expect_now("rst_have_frame", {31'd0, have_frame}, 32'd0);
    expect_now("rst_gfx", {31'd0, playfield_gfx}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int v = 0; v < 256; v += 32) probe_rd(v, v);
    random_probes(8);

    // 2. Full load and swap
    scenario2_frame();
    full_load_check(0);
    pulse_vsync();
    expect_now("busy_idle", {31'd0, busy}, 32'd0);
    scenario2_probes();
    probe_rd(256, 272);

    // 3. Out-of-range rows
    probe_rd(0, 8);
    probe_rd(0, 240);
    probe_rd(0, 0);

    // 5a. Double buffering: vsync mid-load must not swap
    foreach (fr[i]) fr[i] = 32'd0;
    do_start();
    send_bytes(60, 0, 0);
    pulse_vsync();
    probe_rd(0, 16);
    send_bytes(NBYTES - 60, 1, 0);
    pulse_vsync();
    probe_rd(0, 16);

    // 4. Backpressure, gaps, start during LOAD, held 113th byte
    foreach (fr[i]) fr[i] = $urandom;
    base = acc_cnt;
    do_start();
    send_bytes(50, 1, 0);
    do_start();
    send_bytes(NBYTES - 50, 1, 0);
    expect_now("accepted_gaps", 32'(acc_cnt - base), 32'(NBYTES));
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      expect_now("held_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    expect_now("held_count", 32'(acc_cnt - base), 32'(NBYTES));
    pulse_vsync();
    random_probes(40);

    // 5b. Final byte on the same edge as a vsync rise
    foreach (fr[i]) fr[i] = $urandom;
    do_start();
    send_bytes(NBYTES - 1, 1, 0);
    send_bytes(1, 0, 1);
    expect_now("busy_after_vs_last", {31'd0, busy}, 32'd1);
    random_probes(6);
    pulse_vsync();
    random_probes(20);

    // 6. Reset mid-load
    foreach (fr[i]) fr[i] = $urandom;
    do_start();
    send_bytes(50, 1, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    expect_now("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    expect_now("midrst_busy", {31'd0, busy}, 32'd0);
    expect_now("midrst_have_frame", {31'd0, have_frame}, 32'd0);
    expect_now("midrst_gfx", {31'd0, playfield_gfx}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    probe_rd(0, 16);
    scenario2_frame();
    full_load_check(1);
    pulse_vsync();
    scenario2_probes();
    random_probes(10);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
